// File: rtl/kanagawa_show_ahead_fifo_drain.sv
// rtl/kanagawa_show_ahead_fifo_drain.sv - show-ahead FIFO read side to registered valid/ready stream via 2-entry skid buffer; optional stall counter under KANAGAWA_FIFO_DRAIN_STATS_EN
module kanagawa_show_ahead_fifo_drain #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 i_clock,
   input  logic                 i_rst_n,
   input  logic                 i_fifo_empty,
   input  logic [WIDTH-1:0]     i_fifo_q,
   output logic                 o_fifo_rdreq,
   output logic                 o_out_valid,
   output logic [WIDTH-1:0]     o_out_data,
   input  logic                 i_out_ready,
   output logic [1:0]           o_occupancy,
   output logic [CNT_WIDTH-1:0] o_stall_count
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   occ_t             r_occ;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;
   logic             w_push;
   logic             w_pop;

   // Pop the FIFO whenever there is room; out_ready is deliberately not involved,
   // which is what the second (skid) entry buys us.
   assign w_push       = i_rst_n & ~i_fifo_empty & (r_occ != OCC_TWO);
   assign w_pop        = (r_occ != OCC_EMPTY) & i_out_ready;
   assign o_fifo_rdreq = w_push;
   assign o_out_valid  = (r_occ != OCC_EMPTY);
   assign o_out_data   = r_head;
   assign o_occupancy  = r_occ;

   // Occupancy FSM: head is always the oldest entry, skid only fills when head stalls
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_occ  <= OCC_EMPTY;
         r_head <= '0;
         r_skid <= '0;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (w_push) begin
                  r_head <= i_fifo_q;
                  r_occ  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (w_push && w_pop) begin
                  r_head <= i_fifo_q;
               end else if (w_push) begin
                  r_skid <= i_fifo_q;
                  r_occ  <= OCC_TWO;
               end else if (w_pop) begin
                  r_occ  <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (w_pop) begin
                  r_head <= r_skid;
                  r_occ  <= OCC_ONE;
               end
            end
            default: begin
               r_occ <= OCC_EMPTY;
            end
         endcase
      end
   end

`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
   logic [CNT_WIDTH-1:0] r_stall_count;

   // Count back-pressure cycles, saturating instead of wrapping
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= '0;
      end else if (o_out_valid && !i_out_ready && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign o_stall_count = r_stall_count;
`else
   assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_kanagawa_show_ahead_fifo_drain.sv
// tb/tb_kanagawa_show_ahead_fifo_drain.sv - self-checking bench for kanagawa_show_ahead_fifo_drain against a queue-based reference model
module tb_kanagawa_show_ahead_fifo_drain;

   localparam int WIDTH     = 32;
   localparam int CNT_WIDTH = 4;

   logic                 clk;
   logic                 i_rst_n;
   logic                 i_fifo_empty;
   logic [WIDTH-1:0]     i_fifo_q;
   logic                 o_fifo_rdreq;
   logic                 o_out_valid;
   logic [WIDTH-1:0]     o_out_data;
   logic                 i_out_ready;
   logic [1:0]           o_occupancy;
   logic [CNT_WIDTH-1:0] o_stall_count;

   int checks = 0;
   int errors = 0;

   // Reference: fq is the upstream FIFO contents, mb the words held by the drain stage
   logic [WIDTH-1:0] fq[$];
   logic [WIDTH-1:0] mb[$];
   logic [WIDTH-1:0] last_data;
   int               stall_model;

   kanagawa_show_ahead_fifo_drain #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .i_clock       (clk),
      .i_rst_n       (i_rst_n),
      .i_fifo_empty  (i_fifo_empty),
      .i_fifo_q      (i_fifo_q),
      .o_fifo_rdreq  (o_fifo_rdreq),
      .o_out_valid   (o_out_valid),
      .o_out_data    (o_out_data),
      .i_out_ready   (i_out_ready),
      .o_occupancy   (o_occupancy),
      .o_stall_count (o_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] exp_stall();
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
      return WIDTH'(stall_model);
`else
      return '0;
`endif
   endfunction

   task automatic model_reset();
      mb.delete();
      last_data   = '0;
      stall_model = 0;
   endtask

   // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge
   task automatic cycle(input bit ready);
      bit exp_rdreq;
      bit exp_valid;
      i_out_ready  = ready;
      i_fifo_empty = (fq.size() == 0);
      i_fifo_q     = (fq.size() != 0) ? fq[0] : WIDTH'($urandom);
      @(negedge clk);
      exp_rdreq = i_rst_n && (fq.size() != 0) && (mb.size() < 2);
      exp_valid = (mb.size() != 0);
      chk("rdreq", WIDTH'(o_fifo_rdreq), WIDTH'(exp_rdreq));
      chk("valid", WIDTH'(o_out_valid), WIDTH'(exp_valid));
      chk("data", o_out_data, exp_valid ? mb[0] : last_data);
      chk("occupancy", WIDTH'(o_occupancy), WIDTH'(mb.size()));
      chk("stall_count", WIDTH'(o_stall_count), exp_stall());
      @(posedge clk);
      if (i_rst_n) begin
         if (exp_valid && !ready && stall_model < (2**CNT_WIDTH - 1)) stall_model++;
         if (exp_valid && ready) last_data = mb.pop_front();
         if (exp_rdreq) mb.push_back(fq.pop_front());
      end
      #1;
   endtask

   initial begin
      // Reset with a non-empty FIFO: no pop while held, first pop right after release
      i_rst_n      = 1'b0;
      i_out_ready  = 1'b1;
      i_fifo_empty = 1'b0;
      i_fifo_q     = 32'hA5;
      model_reset();
      fq.push_back(32'hA5);
      #1;
      chk("reset_rdreq_async", WIDTH'(o_fifo_rdreq), '0);
      chk("reset_valid_async", WIDTH'(o_out_valid), '0);
      cycle(1'b1);
      cycle(1'b1);
      i_rst_n = 1'b1;
      cycle(1'b1);
      cycle(1'b1);
      cycle(1'b1);

      // Full-rate streaming of 0..99
      for (int i = 0; i < 100; i++) fq.push_back(WIDTH'(i));
      for (int i = 0; i < 104; i++) cycle(1'b1);

      // Back-pressure for 10 cycles, then release
      for (int i = 0; i < 20; i++) fq.push_back(WIDTH'($urandom));
      for (int i = 0; i < 10; i++) cycle(1'b0);
      chk("bp_occupancy_full", WIDTH'(o_occupancy), WIDTH'(2));
      for (int i = 0; i < 24; i++) cycle(1'b1);

      // Toggling ready with the FIFO running dry mid-stream, then random traffic with refills
      for (int i = 0; i < 7; i++) fq.push_back(WIDTH'($urandom));
      for (int i = 0; i < 20; i++) cycle(i[0]);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) fq.push_back(WIDTH'($urandom));
         cycle(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 200; i++) cycle(1'b1);
      chk("all_drained", WIDTH'(fq.size() + mb.size()), '0);

      // Asynchronous reset mid-clock while two entries are buffered
      for (int i = 0; i < 6; i++) fq.push_back(WIDTH'($urandom));
      cycle(1'b0);
      cycle(1'b0);
      cycle(1'b0);
      chk("pre_reset_occupancy", WIDTH'(o_occupancy), WIDTH'(2));
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("mid_reset_valid", WIDTH'(o_out_valid), '0);
      chk("mid_reset_occupancy", WIDTH'(o_occupancy), '0);
      chk("mid_reset_rdreq", WIDTH'(o_fifo_rdreq), '0);
      model_reset();
      cycle(1'b1);
      i_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) cycle(1'b1);

      // Saturating stall counter over 20+ stalled cycles
      for (int i = 0; i < 25; i++) fq.push_back(WIDTH'($urandom));
      for (int i = 0; i < 22; i++) cycle(1'b0);
`ifdef KANAGAWA_FIFO_DRAIN_STATS_EN
      chk("stall_saturated", WIDTH'(o_stall_count), WIDTH'(15));
`else
      chk("stall_disabled", WIDTH'(o_stall_count), '0);
`endif
      for (int i = 0; i < 30; i++) cycle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
